// File: rtl/seven_seg_scan_driver.sv
// Multiplexed N-digit seven-segment driver.
// A value is loaded through a valid/busy handshake. It is shown either as hex
// or as decimal. Decimal values go through a sequential double-dabble converter.
// The digits are scanned with a dead time at the start of each dwell, and the
// block supports leading-zero blanking and an overflow glyph.
//
// Handshake: a load is accepted on the clock edge where value_valid=1 and
// busy=0; value and dec_mode are captured on that edge. busy is high from the
// next cycle until the end of the commit cycle, and any value_valid seen while
// busy=1 is dropped rather than queued.
module seven_seg_scan_driver #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 1000,
    parameter int DIGITS     = 4,
    parameter int DATA_W     = 16,
    parameter int GHOST_CYC  = 16,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] value,
    input  logic              value_valid,
    input  logic              dec_mode,
    input  logic              blank_lz,
    input  logic [DIGITS-1:0] dp_in,
    output logic              busy,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg,
    output logic              dp
);

    // Number of decimal digits needed for the largest DATA_W-bit value.
    function automatic int bcd_nibbles(input int w);
        longint m;
        int     n;
        m = (longint'(1) << w) - 1;
        n = 0;
        while (m > 0) begin
            m = m / 10;
            n = n + 1;
        end
        return n;
    endfunction

    localparam int TICK  = CLK_HZ / REFRESH_HZ;
    localparam int CNT_W = (TICK > 1) ? $clog2(TICK) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BC_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int NIB   = bcd_nibbles(DATA_W);
    localparam int BW    = 4 * NIB;
    localparam int DW4   = 4 * DIGITS;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_COMMIT  = 2'd2
    } state_t;

    // state is the observable FSM state for checkers
    state_t state;
    state_t state_next;

    logic              do_accept;
    logic              do_convert;
    logic              do_commit;

    logic [DATA_W-1:0] sh_q;
    logic [BW-1:0]     bcd_q;
    logic [BW-1:0]     bcd_adj;
    logic              dec_q;
    logic [BC_W-1:0]   bit_cnt;

    logic [DW4-1:0]    disp_q;
    logic              ovf_q;

    logic [DATA_W+DW4-1:0] hex_wide;
    logic [BW+DW4-1:0]     bcd_wide;
    logic [DW4-1:0]        commit_digits;
    logic                  commit_ovf;

    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_next;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_next;

    logic [DIGITS-1:0] blank_vec;
    logic [DIGITS-1:0] an_n;
    logic [6:0]        seg_n;
    logic              dp_n;
    logic [3:0]        cur_nib;
    logic              upper_zero;

    // Active-high glyphs, seg[0]=A .. seg[6]=G; b and d are lowercase.
    function automatic logic [6:0] hex_glyph(input logic [3:0] d);
        case (d)
            4'h0:    hex_glyph = 7'h3F;
            4'h1:    hex_glyph = 7'h06;
            4'h2:    hex_glyph = 7'h5B;
            4'h3:    hex_glyph = 7'h4F;
            4'h4:    hex_glyph = 7'h66;
            4'h5:    hex_glyph = 7'h6D;
            4'h6:    hex_glyph = 7'h7D;
            4'h7:    hex_glyph = 7'h07;
            4'h8:    hex_glyph = 7'h7F;
            4'h9:    hex_glyph = 7'h6F;
            4'hA:    hex_glyph = 7'h77;
            4'hB:    hex_glyph = 7'h7C;
            4'hC:    hex_glyph = 7'h39;
            4'hD:    hex_glyph = 7'h5E;
            4'hE:    hex_glyph = 7'h79;
            default: hex_glyph = 7'h71;
        endcase
    endfunction

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // FSM next state: hex loads commit directly, decimal loads convert first
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (value_valid) state_next = dec_mode ? S_CONVERT : S_COMMIT;
            S_CONVERT: if (bit_cnt == BC_W'(DATA_W - 1)) state_next = S_COMMIT;
            S_COMMIT:  state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // FSM outputs: one strobe per datapath action
    always_comb begin
        do_accept  = 1'b0;
        do_convert = 1'b0;
        do_commit  = 1'b0;
        case (state)
            S_IDLE:    do_accept  = value_valid;
            S_CONVERT: do_convert = 1'b1;
            S_COMMIT:  do_commit  = 1'b1;
            default:   do_accept  = 1'b0;
        endcase
    end

    // Double-dabble correction: add 3 to every BCD nibble that is 5 or more
    always_comb begin
        bcd_adj = bcd_q;
        for (int n = 0; n < NIB; n++) begin
            if (bcd_q[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
        end
    end

    // Capture on accept, then shift {bcd, value} left once per convert cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q    <= '0;
            bcd_q   <= '0;
            dec_q   <= 1'b0;
            bit_cnt <= '0;
        end else if (do_accept) begin
            sh_q    <= value;
            bcd_q   <= '0;
            dec_q   <= dec_mode;
            bit_cnt <= '0;
        end else if (do_convert) begin
            {bcd_q, sh_q} <= {bcd_adj[BW-2:0], sh_q, 1'b0};
            bit_cnt       <= bit_cnt + BC_W'(1);
        end
    end

    // Digits that fit the display, and whether anything was left over above them
    assign hex_wide      = {{DW4{1'b0}}, sh_q};
    assign bcd_wide      = {{DW4{1'b0}}, bcd_q};
    assign commit_digits = dec_q ? bcd_wide[DW4-1:0] : hex_wide[DW4-1:0];
    assign commit_ovf    = dec_q ? (|bcd_wide[BW+DW4-1:DW4]) : (|hex_wide[DATA_W+DW4-1:DW4]);

    // Display registers and overflow flag change together in the commit cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_q <= '0;
            ovf_q  <= 1'b0;
        end else if (do_commit) begin
            disp_q <= commit_digits;
            ovf_q  <= commit_ovf;
        end
    end

    // Next dwell count and digit index; the output flops are aligned to these
    always_comb begin
        idx_next = idx_q;
        if (cnt_q == CNT_W'(TICK - 1)) begin
            cnt_next = '0;
            idx_next = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end else begin
            cnt_next = cnt_q + CNT_W'(1);
        end
    end

    // Scan counters run freely and are never disturbed by loads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_next;
            idx_q <= idx_next;
        end
    end

    // Leading-zero blanking: digit i>0 blanks when it and every higher digit is zero
    always_comb begin
        blank_vec  = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero   = upper_zero & (disp_q[4*i +: 4] == 4'd0);
            blank_vec[i] = (i != 0) && upper_zero && blank_lz && !ovf_q;
        end
    end

    // Active-high view of the pins for the upcoming cycle
    always_comb begin
        cur_nib = disp_q[4*int'(idx_next) +: 4];
        an_n    = '0;
        if (cnt_next >= CNT_W'(GHOST_CYC) && !blank_vec[idx_next]) an_n[idx_next] = 1'b1;
        if (ovf_q) begin
            seg_n = 7'h40;
            dp_n  = 1'b0;
        end else if (blank_vec[idx_next]) begin
            seg_n = 7'h00;
            dp_n  = 1'b0;
        end else begin
            seg_n = hex_glyph(cur_nib);
            dp_n  = dp_in[idx_next];
        end
    end

    // Registered pins; polarity is applied only here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an   <= {DIGITS{ACTIVE_LOW}};
            seg  <= {7{ACTIVE_LOW}};
            dp   <= ACTIVE_LOW;
            busy <= 1'b0;
        end else begin
            an   <= ACTIVE_LOW ? ~an_n  : an_n;
            seg  <= ACTIVE_LOW ? ~seg_n : seg_n;
            dp   <= ACTIVE_LOW ? ~dp_n  : dp_n;
            busy <= (state_next != S_IDLE);
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: directed and random loads, with expected
// displays queued by the driver and checked by an independent monitor.
module tb_seven_seg_scan_driver;

  localparam int DIGITS = 4;
  localparam int DATA_W = 16;
  localparam int EW     = 9 + 9 * DIGITS;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] value;
  logic              value_valid;
  logic              dec_mode;
  logic              blank_lz;
  logic [DIGITS-1:0] dp_in;
  logic              busy;
  logic [DIGITS-1:0] an;
  logic [6:0]        seg;
  logic              dp;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(
    .CLK_HZ     (1000),
    .REFRESH_HZ (100),
    .DIGITS     (DIGITS),
    .DATA_W     (DATA_W),
    .GHOST_CYC  (2),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .value       (value),
    .value_valid (value_valid),
    .dec_mode    (dec_mode),
    .blank_lz    (blank_lz),
    .dp_in       (dp_in),
    .busy        (busy),
    .an          (an),
    .seg         (seg),
    .dp          (dp)
  );

  // ---------------- scoreboard state ----------------
  // entry: [7:0] expected busy cycles, [8] check scan, then per digit {shown, dp pin, seg pins}
  logic [EW-1:0] exp_q[$];
  int checks   = 0;
  int errors   = 0;
  int n_pushed = 0;
  int mon_done = 0;
  bit probe_req = 1'b0;
  int m_bcnt = 0;
  bit m_in_busy = 1'b0;

  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: digits by division, blanking by magnitude, overflow by range
  function automatic logic [EW-1:0] model(input int unsigned v, input bit dec, input bit blz,
                                          input logic [DIGITS-1:0] dpv, input int blen, input bit chk);
    logic [EW-1:0] e;
    int unsigned   base, lim, pw, digit;
    bit            ovf, blank;
    logic [6:0]    s;
    logic          p;
    base = dec ? 10 : 16;
    lim  = 1;
    for (int k = 0; k < DIGITS; k++) lim = lim * base;
    ovf  = (v >= lim);
    e    = '0;
    e[7:0] = blen[7:0];
    e[8]   = chk;
    pw = 1;
    for (int d = 0; d < DIGITS; d++) begin
      digit = (v / pw) % base;
      blank = blz && !ovf && (d > 0) && (v < pw);
      s = ovf ? ~7'h40 : ~glyph_tab[digit];
      p = ovf ? 1'b1 : ~dpv[d];
      e[9 + 9*d +: 9] = {~blank, p, s};
      pw = pw * base;
    end
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_load(input int unsigned v, input bit dec, input bit push, input bit chk);
    int          guard;
    logic [31:0] vv;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) check("load_wait_busy", 32'(busy), 32'd0);
    vv          = v;
    value       = vv[DATA_W-1:0];
    dec_mode    = dec;
    value_valid = 1'b1;
    if (push) begin
      exp_q.push_back(model(v, dec, blank_lz, dp_in, dec ? DATA_W + 1 : 1, chk));
      n_pushed++;
    end
    @(negedge clk);
    value_valid = 1'b0;
  endtask

  task automatic wait_mon();
    int guard;
    guard = 0;
    while (mon_done < n_pushed && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) check("monitor_timeout", 32'(mon_done), 32'(n_pushed));
  endtask

  task automatic probe(input bit blz);
    blank_lz = blz;
    exp_q.push_back(model(0, 1'b0, blz, dp_in, 0, 1'b1));
    n_pushed++;
    probe_req = 1'b1;
    wait_mon();
  endtask

  // ---------------- monitor ----------------
  task automatic observe(input logic [EW-1:0] e);
    int         act_cnt [DIGITS];
    logic [6:0] bad_seg [DIGITS];
    logic       bad_dp  [DIGITS];
    bit         seg_err [DIGITS];
    bit         dp_err  [DIGITS];
    int         n_act, max_act;
    for (int d = 0; d < DIGITS; d++) begin
      act_cnt[d] = 0; seg_err[d] = 0; dp_err[d] = 0; bad_seg[d] = '0; bad_dp[d] = 1'b0;
    end
    max_act = 0;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 4 * 10; c++) begin
      @(negedge clk);
      n_act = 0;
      for (int d = 0; d < DIGITS; d++) begin
        if (an[d] == 1'b0) begin
          n_act++;
          act_cnt[d]++;
          if (seg !== e[9 + 9*d +: 7] && !seg_err[d]) begin seg_err[d] = 1; bad_seg[d] = seg; end
          if (dp !== e[9 + 9*d + 7] && !dp_err[d]) begin dp_err[d] = 1; bad_dp[d] = dp; end
        end
      end
      if (n_act > max_act) max_act = n_act;
    end
    check("anodes_at_most_one", 32'(max_act > 1), 32'd0);
    for (int d = 0; d < DIGITS; d++) begin
      check($sformatf("d%0d_active_cycles", d), 32'(act_cnt[d]), e[9 + 9*d + 8] ? 32'd8 : 32'd0);
      if (e[9 + 9*d + 8]) begin
        check($sformatf("d%0d_seg", d), seg_err[d] ? 32'(bad_seg[d]) : 32'(e[9 + 9*d +: 7]),
              32'(e[9 + 9*d +: 7]));
        check($sformatf("d%0d_dp", d), seg_err[d] || !dp_err[d] ? 32'(e[9 + 9*d + 7]) : 32'(bad_dp[d]),
              32'(e[9 + 9*d + 7]));
      end
    end
  endtask

  initial begin : monitor
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_bcnt = 0;
        m_in_busy = 1'b0;
      end else if (busy) begin
        m_in_busy = 1'b1;
        m_bcnt++;
        if (m_bcnt > 200) begin
          check("busy_stuck", 32'(m_bcnt), 32'd17);
          m_bcnt = 0;
          m_in_busy = 1'b0;
        end
      end else if (m_in_busy || probe_req) begin
        m_in_busy = 1'b0;
        probe_req = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_load", 32'(m_bcnt), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("busy_cycles", 32'(m_bcnt), 32'(e[7:0]));
          if (e[8]) observe(e);
        end
        m_bcnt = 0;
        mon_done++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    int unsigned v;
    rst = 1'b1; value = '0; value_valid = 1'b0; dec_mode = 1'b0; blank_lz = 1'b0; dp_in = '0;
    repeat (3) @(negedge clk);
    check("reset_an", 32'(an), 32'hF);
    check("reset_seg", 32'(seg), 32'h7F);
    check("reset_dp", 32'(dp), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // reset display: all zeros, then only digit 0 with blanking
    probe(1'b0);
    probe(1'b1);

    // hex loads
    blank_lz = 1'b0; dp_in = 4'b0010;
    do_load(32'hA3F0, 1'b0, 1'b1, 1'b1); wait_mon();
    blank_lz = 1'b1; dp_in = 4'b0000;
    do_load(32'h00F0, 1'b0, 1'b1, 1'b1); wait_mon();

    // decimal loads
    blank_lz = 1'b0;
    do_load(1234, 1'b1, 1'b1, 1'b1); wait_mon();
    blank_lz = 1'b1;
    do_load(7, 1'b1, 1'b1, 1'b1); wait_mon();

    // decimal overflow ignores blanking and decimal points
    dp_in = 4'hF;
    do_load(65535, 1'b1, 1'b1, 1'b1); wait_mon();
    dp_in = 4'h0; blank_lz = 1'b0;

    // a request while converting is dropped
    do_load(42, 1'b1, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    value = 16'd999; dec_mode = 1'b0; value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    wait_mon();

    // a request the cycle after busy falls is accepted
    do_load(500, 1'b1, 1'b1, 1'b0);
    do_load(77, 1'b1, 1'b1, 1'b1);
    wait_mon();

    // reset in the middle of a conversion
    do_load(9999, 1'b1, 1'b0, 1'b0);
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_an", 32'(an), 32'hF);
    check("abort_seg", 32'(seg), 32'h7F);
    check("abort_dp", 32'(dp), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    probe(1'b0);
    do_load(9999, 1'b1, 1'b1, 1'b1); wait_mon();

    // random loads
    for (int i = 0; i < 10; i++) begin
      v = $urandom_range(0, 65535) >> $urandom_range(0, 15);
      blank_lz = 1'($urandom_range(0, 1));
      dp_in = 4'($urandom_range(0, 15));
      do_load(v, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
      wait_mon();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
